// File: rtl/decode_stage.sv
// decode_stage: instruction decode for a 5-stage RV32I pipeline.
// Extracts operands and immediates, bypasses the writeback port into the
// read operands, detects load-use hazards and owns the ID/EX register.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    output logic [4:0]  r1_idx,
    output logic [4:0]  r2_idx,
    input  logic [31:0] reg1_data,
    input  logic [31:0] reg2_data,
    input  logic        wb_wr_en,
    input  logic [4:0]  wb_wr_idx,
    input  logic [31:0] wb_wr_data,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        stall_out,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1_idx,
    output logic [4:0]  ex_rs2_idx,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_mem_read,
    output logic [15:0] stall_count
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_no_rd;
    logic        w_load_use;
    logic        w_bubble;

    // ID/EX register
    logic        r_ex_valid;
    logic [31:0] r_ex_pc;
    logic [31:0] r_ex_rs1_val;
    logic [31:0] r_ex_rs2_val;
    logic [31:0] r_ex_imm;
    logic [4:0]  r_ex_rd;
    logic [4:0]  r_ex_rs1_idx;
    logic [4:0]  r_ex_rs2_idx;
    logic [6:0]  r_ex_opcode;
    logic [2:0]  r_ex_funct3;
    logic        r_ex_funct7b5;
    logic        r_ex_mem_read;
    logic [15:0] r_stall_count;

    assign w_opcode = id_instr[6:0];
    assign w_rd     = id_instr[11:7];
    assign w_funct3 = id_instr[14:12];
    assign r1_idx   = id_instr[19:15];
    assign r2_idx   = id_instr[24:20];

    // x0 reads as zero; a same-cycle writeback wins over the stale RF read
    assign w_rs1_val = (r1_idx == 5'd0) ? 32'd0 :
                       (wb_wr_en && (wb_wr_idx == r1_idx)) ? wb_wr_data : reg1_data;
    assign w_rs2_val = (r2_idx == 5'd0) ? 32'd0 :
                       (wb_wr_en && (wb_wr_idx == r2_idx)) ? wb_wr_data : reg2_data;

    assign w_use_rs1 = !((w_opcode == OpLui) || (w_opcode == OpAuipc) || (w_opcode == OpJal));
    assign w_use_rs2 = (w_opcode == OpReg) || (w_opcode == OpStore) || (w_opcode == OpBranch);
    // Stores and branches carry immediate bits in the rd field
    assign w_no_rd   = (w_opcode == OpStore) || (w_opcode == OpBranch);

    assign w_load_use = id_valid && r_ex_valid && r_ex_mem_read && (r_ex_rd != 5'd0) &&
                        ((w_use_rs1 && (r_ex_rd == r1_idx)) ||
                         (w_use_rs2 && (r_ex_rd == r2_idx)));

    // Flush overrides everything; otherwise hold or a hazard freezes IF/ID
    assign stall_out = !flush && (ex_hold || w_load_use);
    assign w_bubble  = !flush && !ex_hold && w_load_use;

    // Immediate generation, sign-extended from instr[31]
    always_comb begin
        w_imm = 32'd0;
        case (w_opcode)
            OpLoad, OpImm, OpJalr: w_imm = {{20{id_instr[31]}}, id_instr[31:20]};
            OpStore:  w_imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
            OpBranch: w_imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                               id_instr[30:25], id_instr[11:8], 1'b0};
            OpLui, OpAuipc: w_imm = {id_instr[31:12], 12'd0};
            OpJal:    w_imm = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                               id_instr[20], id_instr[30:21], 1'b0};
            default:  w_imm = 32'd0;
        endcase
    end

    // ID/EX register update: flush > hold > load-use bubble > advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= 32'd0;
            r_ex_rs1_val  <= 32'd0;
            r_ex_rs2_val  <= 32'd0;
            r_ex_imm      <= 32'd0;
            r_ex_rd       <= 5'd0;
            r_ex_rs1_idx  <= 5'd0;
            r_ex_rs2_idx  <= 5'd0;
            r_ex_opcode   <= 7'd0;
            r_ex_funct3   <= 3'd0;
            r_ex_funct7b5 <= 1'b0;
            r_ex_mem_read <= 1'b0;
        end else if (flush) begin
            r_ex_valid    <= 1'b0;
            r_ex_mem_read <= 1'b0;
        end else if (ex_hold) begin
            // EX is busy: keep the current payload
        end else if (w_load_use) begin
            r_ex_valid    <= 1'b0;
            r_ex_mem_read <= 1'b0;
            r_ex_rd       <= 5'd0;
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_pc       <= id_pc;
            r_ex_rs1_val  <= w_rs1_val;
            r_ex_rs2_val  <= w_rs2_val;
            r_ex_imm      <= w_imm;
            r_ex_rd       <= w_no_rd ? 5'd0 : w_rd;
            r_ex_rs1_idx  <= r1_idx;
            r_ex_rs2_idx  <= r2_idx;
            r_ex_opcode   <= w_opcode;
            r_ex_funct3   <= w_funct3;
            r_ex_funct7b5 <= id_instr[30];
            r_ex_mem_read <= id_valid && (w_opcode == OpLoad);
        end
    end

    // Saturating count of load-use bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 16'd0;
        end else if (w_bubble && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_rs1_val  = r_ex_rs1_val;
    assign ex_rs2_val  = r_ex_rs2_val;
    assign ex_imm      = r_ex_imm;
    assign ex_rd       = r_ex_rd;
    assign ex_rs1_idx  = r_ex_rs1_idx;
    assign ex_rs2_idx  = r_ex_rs2_idx;
    assign ex_opcode   = r_ex_opcode;
    assign ex_funct3   = r_ex_funct3;
    assign ex_funct7b5 = r_ex_funct7b5;
    assign ex_mem_read = r_ex_mem_read;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against an
// architectural model (register-file array plus ID/EX payload variables).
module tb_decode_stage;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [4:0]  r1_idx;
    logic [4:0]  r2_idx;
    logic [31:0] reg1_data;
    logic [31:0] reg2_data;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_idx;
    logic [31:0] wb_wr_data;
    logic        ex_hold;
    logic        flush;
    logic        stall_out;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1_idx;
    logic [4:0]  ex_rs2_idx;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_mem_read;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Architectural register file and expected ID/EX contents
    logic [31:0] rf [32];
    logic        m_valid, m_mr, m_f7b5, m_known, m_rdk;
    logic [31:0] m_pc, m_rs1v, m_rs2v, m_imm;
    logic [4:0]  m_rd, m_rs1i, m_rs2i;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic [15:0] m_cnt;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .r1_idx      (r1_idx),
        .r2_idx      (r2_idx),
        .reg1_data   (reg1_data),
        .reg2_data   (reg2_data),
        .wb_wr_en    (wb_wr_en),
        .wb_wr_idx   (wb_wr_idx),
        .wb_wr_data  (wb_wr_data),
        .ex_hold     (ex_hold),
        .flush       (flush),
        .stall_out   (stall_out),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs1_val  (ex_rs1_val),
        .ex_rs2_val  (ex_rs2_val),
        .ex_imm      (ex_imm),
        .ex_rd       (ex_rd),
        .ex_rs1_idx  (ex_rs1_idx),
        .ex_rs2_idx  (ex_rs2_idx),
        .ex_opcode   (ex_opcode),
        .ex_funct3   (ex_funct3),
        .ex_funct7b5 (ex_funct7b5),
        .ex_mem_read (ex_mem_read),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Immediate value as signed arithmetic on the instruction's fields
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] v;
        v = 32'd0;
        case (i[6:0])
            OpLoad, OpImm, OpJalr:
                v = 32'(i[30:20]) - (i[31] ? 32'd2048 : 32'd0);
            OpStore:
                v = 32'({i[30:25], i[11:7]}) - (i[31] ? 32'd2048 : 32'd0);
            OpBranch:
                v = 32'(i[11:8]) * 32'd2 + 32'(i[30:25]) * 32'd32 + 32'(i[7]) * 32'd2048
                    - (i[31] ? 32'd4096 : 32'd0);
            OpLui, OpAuipc:
                v = 32'(i[31:12]) * 32'd4096;
            OpJal:
                v = 32'(i[30:21]) * 32'd2 + 32'(i[20]) * 32'd2048 + 32'(i[19:12]) * 32'd4096
                    - (i[31] ? 32'h0010_0000 : 32'd0);
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_mr = 1'b0; m_f7b5 = 1'b0; m_known = 1'b1; m_rdk = 1'b1;
        m_pc = '0; m_rs1v = '0; m_rs2v = '0; m_imm = '0;
        m_rd = '0; m_rs1i = '0; m_rs2i = '0; m_op = '0; m_f3 = '0; m_cnt = '0;
    endtask

    task automatic check_regs();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        if (m_rdk) chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        if (m_known) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rs1_val", ex_rs1_val, m_rs1v);
            chk("ex_rs2_val", ex_rs2_val, m_rs2v);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rs1_idx", 32'(ex_rs1_idx), 32'(m_rs1i));
            chk("ex_rs2_idx", 32'(ex_rs2_idx), 32'(m_rs2i));
            chk("ex_opcode", 32'(ex_opcode), 32'(m_op));
            chk("ex_funct3", 32'(ex_funct3), 32'(m_f3));
            chk("ex_funct7b5", 32'(ex_funct7b5), 32'(m_f7b5));
        end
    endtask

    // One clock: inputs already applied just after a falling edge
    task automatic cycle();
        logic [31:0] nrf [32];
        logic [6:0]  op;
        logic [4:0]  s1, s2;
        logic        use1, use2, lu;
        s1 = id_instr[19:15];
        s2 = id_instr[24:20];
        op = id_instr[6:0];
        // RF returns pre-write contents; x0 reads garbage to prove it is ignored
        reg1_data = (s1 == 5'd0) ? $urandom : rf[s1];
        reg2_data = (s2 == 5'd0) ? $urandom : rf[s2];
        #1;
        use1 = !(op == OpLui || op == OpAuipc || op == OpJal);
        use2 = (op == OpReg || op == OpStore || op == OpBranch);
        lu = id_valid && m_valid && m_mr && (m_rd != 5'd0) &&
             ((use1 && m_rd == s1) || (use2 && m_rd == s2));
        chk("stall_out", 32'(stall_out), 32'(!flush && (ex_hold || lu)));
        chk("r1_idx", 32'(r1_idx), 32'(s1));
        chk("r2_idx", 32'(r2_idx), 32'(s2));
        // Operands are the architectural values once this cycle's write lands
        nrf = rf;
        if (wb_wr_en) nrf[wb_wr_idx] = wb_wr_data;
        nrf[0] = 32'd0;
        @(posedge clk);
        rf = nrf;
        if (flush) begin
            m_valid = 1'b0; m_mr = 1'b0; m_known = 1'b0; m_rdk = 1'b0;
        end else if (ex_hold) begin
            m_valid = m_valid;
        end else if (lu) begin
            m_valid = 1'b0; m_mr = 1'b0; m_rd = 5'd0; m_known = 1'b0; m_rdk = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_valid = id_valid;
            m_pc    = id_pc;
            m_rs1v  = nrf[s1];
            m_rs2v  = nrf[s2];
            m_imm   = ref_imm(id_instr);
            m_rd    = (op == OpStore || op == OpBranch) ? 5'd0 : id_instr[11:7];
            m_rs1i  = s1;
            m_rs2i  = s2;
            m_op    = op;
            m_f3    = id_instr[14:12];
            m_f7b5  = id_instr[30];
            m_mr    = id_valid && (op == OpLoad);
            m_known = 1'b1; m_rdk = 1'b1;
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic set_id(input logic [31:0] instr);
        id_valid = 1'b1; id_instr = instr; id_pc = $urandom; flush = 1'b0; ex_hold = 1'b0;
        wb_wr_en = 1'b0; wb_wr_idx = 5'd0; wb_wr_data = 32'd0;
    endtask

    logic [31:0] i_lw5, i_add6, i_add133, i_lui5, i_beq, i_addim1, i_addi7;
    logic [6:0]  ops [10];
    logic [15:0] c0;

    initial begin
        i_lw5    = {12'd0, 5'd2, 3'b010, 5'd5, OpLoad};
        i_add6   = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, OpReg};
        i_add133 = {7'd0, 5'd3, 5'd3, 3'b000, 5'd1, OpReg};
        i_lui5   = {20'h12345, 5'd5, OpLui};
        i_beq    = {1'b1, 6'd0, 5'd2, 5'd1, 3'b000, 4'd0, 1'b0, OpBranch};
        i_addim1 = {12'hFFF, 5'd0, 3'b000, 5'd0, OpImm};
        i_addi7  = {12'd3, 5'd1, 3'b000, 5'd7, OpImm};
        ops = '{OpLoad, OpImm, OpJalr, OpStore, OpBranch, OpLui, OpAuipc, OpJal, OpReg,
                7'b1110011};
        for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : $urandom;
        model_reset();

        // Reset values with no clock edge yet
        rst_n = 1'b0; set_id(32'd0); id_valid = 1'b0; reg1_data = '0; reg2_data = '0;
        #1;
        check_regs();
        chk("stall_out_reset", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Same-cycle writeback bypass
        rf[3] = 32'd5;
        set_id(i_add133);
        wb_wr_en = 1'b1; wb_wr_idx = 5'd3; wb_wr_data = 32'd9;
        cycle();
        chk("bypass_rs1", ex_rs1_val, 32'd9);
        chk("bypass_rs2", ex_rs2_val, 32'd9);

        // Load-use: one bubble, then the consumer advances
        set_id(i_lw5); cycle();
        c0 = m_cnt;
        set_id(i_add6); cycle();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_count", 32'(stall_count), 32'(c0 + 16'd1));
        cycle();
        chk("lu_after_valid", 32'(ex_valid), 32'd1);
        chk("lu_after_rd", 32'(ex_rd), 32'd6);

        // LUI does not read rs1, so no hazard
        set_id(i_lw5); cycle();
        set_id(i_lui5); cycle();
        chk("lui_valid", 32'(ex_valid), 32'd1);
        chk("lui_imm", ex_imm, 32'h12345000);

        // Negative branch offset, and addi on x0
        set_id(i_beq); cycle();
        chk("beq_imm", ex_imm, 32'hFFFFF000);
        chk("beq_rd", 32'(ex_rd), 32'd0);
        set_id(i_addim1); cycle();
        chk("addi_x0_rs1", ex_rs1_val, 32'd0);
        chk("addi_imm", ex_imm, 32'hFFFFFFFF);

        // Flush beats a pending load-use
        set_id(i_lw5); cycle();
        c0 = m_cnt;
        set_id(i_add6); flush = 1'b1; cycle();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_count", 32'(stall_count), 32'(c0));

        // Three cycles of EX hold freeze the payload
        set_id(i_addi7); cycle();
        set_id(i_lui5); ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("hold_imm", ex_imm, 32'd3);
            chk("hold_rd", 32'(ex_rd), 32'd7);
        end

        // Randomized traffic with dense register reuse
        for (int n = 0; n < 3000; n++) begin
            id_instr = $urandom;
            id_instr[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            id_instr[11:7]  = 5'($urandom_range(0, 7));
            id_instr[19:15] = 5'($urandom_range(0, 7));
            id_instr[24:20] = 5'($urandom_range(0, 7));
            id_valid   = ($urandom_range(0, 99) < 85);
            id_pc      = $urandom;
            flush      = ($urandom_range(0, 99) < 10);
            ex_hold    = ($urandom_range(0, 99) < 15);
            wb_wr_en   = $urandom_range(0, 1) == 1;
            wb_wr_idx  = 5'($urandom_range(0, 7));
            wb_wr_data = $urandom;
            cycle();
        end

        // Saturation: start the counter just below its ceiling
        set_id(i_lw5);
        force dut.r_stall_count = 16'hFFFD;
        #1;
        release dut.r_stall_count;
        m_cnt = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            set_id(i_lw5); cycle();
            set_id(i_add6); cycle();
        end
        chk("sat_count", 32'(stall_count), 32'h0000FFFF);

        // Asynchronous reset mid-cycle with a load sitting in EX
        set_id(i_lw5); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after reset is a plain advance; old load must not stall
        set_id(i_add6); cycle();
        chk("post_reset_valid", 32'(ex_valid), 32'd1);
        chk("post_reset_count", 32'(stall_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001: clk  input  1  core clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset, asynchronous and active-low.
REQ-003: id_valid  input  1  IF/ID register holds a valid instruction.
REQ-004: id_instr  input  32  instruction word from IF/ID.
REQ-005: id_pc  input  32  PC of id_instr.
REQ-006: r1_idx, r2_idx  output  5 each  register-file read addresses, combinationally id_instr[19:15] and id_instr[24:20].
REQ-007: reg1_data, reg2_data  input  32 each  register-file combinational read data.
REQ-008: wb_wr_en, wb_wr_idx, wb_wr_data  input  1/5/32  copy of the register-file write port, used for bypass.
REQ-009: ex_hold  input  1  EX stage cannot accept a new instruction this cycle.
REQ-010: flush  input  1  kill the instruction in ID (branch/jump redirect).
REQ-011: stall_out  output  1  combinational; IF/ID and PC hold when 1.
REQ-012: ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  output  1/32/32/32/32  registered ID/EX payload.
REQ-013: ex_rd, ex_rs1_idx, ex_rs2_idx, ex_opcode, ex_funct3, ex_funct7b5  output  5/5/5/7/3/1  registered ID/EX decode fields.
REQ-014: ex_mem_read  output  1  registered; ID/EX instruction is a load (opcode 0000011).
REQ-015: stall_count  output  16  load-use bubble counter.

Function
REQ-016: Operand select per port: idx==0 -> 0; else wb_wr_en && wb_wr_idx==idx -> wb_wr_data; else regN_data.
REQ-017: Immediate, all sign-extended from instr[31]: I {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; U {instr[31:12],12'b0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; other opcodes -> 0.
REQ-018: rs1 is used by all opcodes except LUI (0110111), AUIPC (0010111), JAL (1101111); rs2 is used only by R (0110011), S (0100011), B (1100011).
REQ-019: load_use = id_valid && ex_valid && ex_mem_read && ex_rd!=0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)).
REQ-020: Priority per cycle: flush > ex_hold > load_use > normal advance.
REQ-021: flush=1 -> next ex_valid=0, stall_out=0, other ID/EX fields don't-care.
REQ-022: ex_hold=1 (no flush) -> all ID/EX registers retain value, stall_out=1.
REQ-023: load_use (no flush, no ex_hold) -> bubble: next ex_valid=0, ex_mem_read=0, ex_rd=0; stall_out=1.
REQ-024: Normal -> ID/EX captures decoded instruction one cycle later; ex_valid<=id_valid; ex_rd<=0 when opcode is S or B.
REQ-025: When ex_valid=0, ex_mem_read is 0.
REQ-026: stall_count increments by 1 on each load_use bubble cycle, saturating at 0xFFFF.
REQ-027: Latency ID->EX exactly 1 cycle absent stall/hold/flush.

Reset
REQ-028: rst_n low -> immediately, without clk: every registered output is 0 (ex_valid=0, all payload 0, stall_count=0).
REQ-029: Reset deasserted mid-stream -> first edge behaves as normal advance from the all-zero state; no stall from pre-reset state.

Verification
REQ-030: x3=5 in RF, WB writes x3=9 the same cycle ID decodes add x1,x3,x3 -> next cycle ex_rs1_val=ex_rs2_val=9.
REQ-031: lw x5,0(x2) in EX, ID holds add x6,x5,x1 -> stall_out=1, one bubble (ex_valid=0), stall_count +1; next cycle add enters EX.
REQ-032: lw x5 in EX, ID holds lui x5,0x12345 -> no stall; ex_imm=0x12345000.
REQ-033: beq with imm -4096 (instr[31]=1) -> ex_imm=0xFFFFF000, ex_rd=0; addi x0,x0,-1 -> ex_rs1_val=0, ex_imm=0xFFFFFFFF.
REQ-034: flush and load_use both asserted -> stall_out=0, next ex_valid=0, stall_count unchanged; ex_hold for 3 cycles -> ID/EX outputs frozen, stall_out=1 throughout.
REQ-035: Force stall_count to 0xFFFF via repeated load-use -> stays 0xFFFF; assert rst_n low mid-clock -> all outputs 0 before next edge.
